// File: rtl/tt_dpll_pkg.sv
// tt_dpll_pkg: shared FSM state encoding and default DCO code width for the DPLL lock controller.
package tt_dpll_pkg;
    localparam int CODE_W_DEF = 8;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COARSE = 3'd2,
        ST_FINE   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;
endpackage

// File: rtl/tt_sat_addsub.sv
// tt_sat_addsub: saturating add/subtract, clamps to 0 or all-ones and flags the clamp.
module tt_sat_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] y_o,
    output logic         ovf_o
);
    logic [W:0] r;
    always_comb begin
        r     = sub_i ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i} + {1'b0, b_i};
        ovf_o = r[W];
        y_o   = r[W] ? {W{~sub_i}} : r[W-1:0];
    end
endmodule

// File: rtl/tt_dpll_lock_ctrl.sv
// tt_dpll_lock_ctrl: DPLL acquisition/lock FSM driving a DCO code from PFD up/down pulses.
// Define TT_DPLL_LOCK_CTRL_RELOCK_EN to re-acquire on loss of lock instead of faulting.
module tt_dpll_lock_ctrl
    import tt_dpll_pkg::*;
#(
    parameter int CODE_W      = CODE_W_DEF,
    parameter int CODE_INIT   = 128,
    parameter int COARSE_STEP = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4
) (
    input  logic              i_clk_ref,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_up,
    input  logic              i_down,
    output logic [CODE_W-1:0] o_dco_code,
    output logic [2:0]        o_state,
    output logic              o_locked,
    output logic              o_lock_lost,
    output logic              o_fault
);
    localparam int CNT_W = 16;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d, step_res;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_v_q, dir_v_d, dir_up_q, dir_up_d, lost_q, lost_d;
    logic              inc, dec, step_ovf, stuck;
    assign inc = i_up & ~i_down;
    assign dec = i_down & ~i_up;
    // One adder serves both phases; the step size follows the state.
    tt_sat_addsub #(.W(CODE_W)) u_step (
        .a_i   (code_q),
        .b_i   (state_q == ST_COARSE ? CODE_W'(COARSE_STEP) : CODE_W'(1)),
        .sub_i (dec),
        .y_o   (step_res),
        .ovf_o (step_ovf)
    );
    // A clamped result equal to the current code means the code already sits at the bound.
    assign stuck = step_ovf & (step_res == code_q);
    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            code_q   <= CODE_W'(CODE_INIT);
            cnt_q    <= '0;
            dir_v_q  <= 1'b0;
            dir_up_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            dir_v_q  <= dir_v_d;
            dir_up_q <= dir_up_d;
            lost_q   <= lost_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        dir_v_d  = dir_v_q;
        dir_up_d = dir_up_q;
        lost_d   = 1'b0;
        if (!i_enable) begin
            state_d  = ST_IDLE;
            code_d   = CODE_W'(CODE_INIT);
            cnt_d    = '0;
            dir_v_d  = 1'b0;
            dir_up_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    code_d  = CODE_W'(CODE_INIT);
                    cnt_d   = '0;
                end
                ST_SETTLE: begin
                    cnt_d   = (cnt_q == CNT_W'(SETTLE_CYC - 1)) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(SETTLE_CYC - 1)) ? ST_COARSE : ST_SETTLE;
                end
                ST_COARSE: begin
                    cnt_d = '0;
                    if (!(inc | dec) || (dir_v_q && dir_up_q != inc)) state_d = ST_FINE;
                    else if (stuck) state_d = ST_FAULT;
                    else begin
                        state_d  = ST_SETTLE;
                        code_d   = step_res;
                        dir_v_d  = 1'b1;
                        dir_up_d = inc;
                    end
                end
                ST_FINE: begin
                    code_d  = (inc | dec) ? step_res : code_q;
                    cnt_d   = (i_up | i_down) ? '0 : cnt_q + 1'b1;
                    if (!(i_up | i_down) && cnt_q + 1'b1 == CNT_W'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    code_d = (inc | dec) ? step_res : code_q;
                    cnt_d  = (i_up | i_down) ? cnt_q + 1'b1 : '0;
                    if ((i_up | i_down) && cnt_q + 1'b1 == CNT_W'(UNLOCK_CNT)) begin
                        lost_d = 1'b1;
                        cnt_d  = '0;
`ifdef TT_DPLL_LOCK_CTRL_RELOCK_EN
                        state_d  = ST_SETTLE;
                        dir_v_d  = 1'b0;
                        dir_up_d = 1'b0;
`else
                        state_d  = ST_FAULT;
`endif
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end
    always_comb begin
        o_state     = state_q;
        o_dco_code  = code_q;
        o_locked    = (state_q == ST_LOCKED);
        o_fault     = (state_q == ST_FAULT);
        o_lock_lost = lost_q;
    end
endmodule
